// File: rtl/alloc_base_tracker.sv
// alloc_base_tracker
// Watches the commit stream for calls into the allocator routine, follows
// nested call depth until the allocator's own return, and then emits a
// one-cycle write strobe carrying the returned pointer (a0) toward the
// allocation-base circular buffer.
//
// Commit interface: commit_valid_i qualifies every other commit_* input and
// a0_i for that cycle only. There is no ready/back-pressure; a commit with
// commit_valid_i=1 is always consumed on the rising clock edge. When
// commit_valid_i=0, all other commit inputs are don't-care.
module alloc_base_tracker #(
   parameter logic [31:0] MALLOC_ADDR = 32'h0000_0000,
   parameter int          DEPTH_W     = 4,
   parameter int          CNT_W       = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              flush_i,
   input  logic              commit_valid_i,
   input  logic              commit_is_call_i,
   input  logic              commit_is_ret_i,
   input  logic [31:0]       commit_target_i,
   input  logic [31:0]       a0_i,
   output logic              en_write_o,
   output logic [31:0]       base_addr_o,
   output logic              busy_o,
   output logic              lost_o,
   output logic [CNT_W-1:0]  alloc_cnt_o
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_IN_ALLOC = 2'd1,
      ST_EMIT     = 2'd2
   } state_e;

   localparam logic [DEPTH_W-1:0] DEPTH_ONE = {{(DEPTH_W-1){1'b0}}, 1'b1};
   localparam logic [DEPTH_W-1:0] DEPTH_MAX = {DEPTH_W{1'b1}};
   localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

   state_e             state_q, state_d;
   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic [31:0]        base_q, base_d;
   logic               lost_q, lost_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   // A commit flagged as both call and return is treated as a return only.
   logic is_ret, is_call, is_alloc_call;
   assign is_ret        = commit_valid_i & commit_is_ret_i;
   assign is_call       = commit_valid_i & commit_is_call_i & ~commit_is_ret_i;
   assign is_alloc_call = is_call & (commit_target_i == MALLOC_ADDR);

   // Next-state and datapath update; every target defaults to hold.
   always_comb begin
      state_d = state_q;
      depth_d = depth_q;
      base_d  = base_q;
      lost_d  = lost_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (is_alloc_call) begin
               state_d = ST_IN_ALLOC;
               depth_d = '0;
            end
         end
         ST_IN_ALLOC: begin
            if (is_ret) begin
               if (depth_q != '0) begin
                  depth_d = depth_q - DEPTH_ONE;
               end else if (a0_i == 32'h0) begin
                  // Allocator returned NULL: nothing to record.
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_EMIT;
                  base_d  = a0_i;
                  // Counted on entry so the count already includes the
                  // strobe that is visible in EMIT.
                  if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
               end
            end else if (is_call) begin
               if (depth_q == DEPTH_MAX) begin
                  // Depth counter would overflow: give up on this allocation.
                  state_d = ST_IDLE;
                  depth_d = '0;
                  lost_d  = 1'b1;
               end else begin
                  depth_d = depth_q + DEPTH_ONE;
               end
            end
         end
         ST_EMIT: begin
            // Back-to-back allocations: a new allocator call in the strobe
            // cycle starts tracking immediately.
            if (is_alloc_call) begin
               state_d = ST_IN_ALLOC;
               depth_d = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            depth_d = '0;
         end
      endcase
   end

   // State registers; flush clears everything like reset and wins over commits.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         depth_q <= '0;
         base_q  <= '0;
         lost_q  <= 1'b0;
         cnt_q   <= '0;
      end else if (flush_i) begin
         state_q <= ST_IDLE;
         depth_q <= '0;
         base_q  <= '0;
         lost_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         depth_q <= depth_d;
         base_q  <= base_d;
         lost_q  <= lost_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs come straight from registers only.
   assign en_write_o  = (state_q == ST_EMIT);
   assign busy_o      = (state_q != ST_IDLE);
   assign base_addr_o = base_q;
   assign lost_o      = lost_q;
   assign alloc_cnt_o = cnt_q;

endmodule
